a25_wishbone_port_master: RTL and testbench

//  Wishbone B3 classic master for one buffered port. Consumes the valid/accepted

---
 rtl/a25_wishbone_port_master.sv | 151 +++++++++++++++
 tb/tb_a25_wishbone_port_master.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/a25_wishbone_port_master.sv
// Wishbone B3 classic single-beat master for one buffered port.
// Adds a bus watchdog and error reporting on err/timeout.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid/o_accepted  request handshake from the port buffer
//   i_write, i_wdata    request direction and write data
//   i_be, i_addr        byte enables and byte address
//   o_rdata             read data (registered)
//   o_rdata_valid       one-cycle pulse when a read completes
//   o_wb_*              Wishbone master outputs
//   i_wb_dat/ack/err    Wishbone slave responses
//   o_err               one-cycle pulse: cycle ended by err/timeout
//   o_err_sticky        any o_err seen since reset
module a25_wishbone_port_master #(
    parameter int unsigned  TIMEOUT_CYCLES = 255,
    parameter logic [127:0] ERR_RDATA =
        128'hdead_dead_dead_dead_dead_dead_dead_dead
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_accepted,
    input  logic         i_write,
    input  logic [127:0] i_wdata,
    input  logic [15:0]  i_be,
    input  logic [31:0]  i_addr,
    output logic [127:0] o_rdata,
    output logic         o_rdata_valid,
    output logic [31:0]  o_wb_adr,
    output logic [15:0]  o_wb_sel,
    output logic         o_wb_we,
    output logic [127:0] o_wb_dat,
    output logic         o_wb_cyc,
    output logic         o_wb_stb,
    input  logic [127:0] i_wb_dat,
    input  logic         i_wb_ack,
    input  logic         i_wb_err,
    output logic         o_err,
    output logic         o_err_sticky
);

    localparam int unsigned CW =
        $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST =
        CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] C_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_adr;
    logic [15:0]    r_sel;
    logic           r_we;
    logic [127:0]   r_dat;
    logic           r_cyc;
    logic           r_stb;
    logic [127:0]   r_rdata;
    logic           r_rdata_valid;
    logic           r_err;
    logic           r_err_sticky;

    logic           w_timeout;
    logic           w_fail;
    logic           w_end;

    // Watchdog fires only when the slave stays silent on
    // the last allowed cycle; err always beats ack.
    assign w_timeout = (r_cnt == C_LAST);
    assign w_fail    = i_wb_err |
                       (w_timeout & ~i_wb_ack);
    assign w_end     = i_wb_ack | w_fail;

    assign o_accepted = ~i_rst & i_valid &
                        (r_state == S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_adr         <= '0;
            r_sel         <= '0;
            r_we          <= 1'b0;
            r_dat         <= '0;
            r_cyc         <= 1'b0;
            r_stb         <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_err         <= 1'b0;
            r_err_sticky  <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_err         <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_adr   <= i_addr;
                        r_sel   <= i_be;
                        r_we    <= i_write;
                        r_dat   <= i_wdata;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (w_end) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_state <= S_DONE;
                        if (!r_we) begin
                            r_rdata_valid <= 1'b1;
                            r_rdata <= w_fail ? ERR_RDATA
                                              : i_wb_dat;
                        end
                        if (w_fail) begin
                            r_err        <= 1'b1;
                            r_err_sticky <= 1'b1;
                        end
                    end else if (r_cnt != C_MAX) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_wb_adr      = r_adr;
    assign o_wb_sel      = r_sel;
    assign o_wb_we       = r_we;
    assign o_wb_dat      = r_dat;
    assign o_wb_cyc      = r_cyc;
    assign o_wb_stb      = r_stb;
    assign o_rdata       = r_rdata;
    assign o_rdata_valid = r_rdata_valid;
    assign o_err         = r_err;
    assign o_err_sticky  = r_err_sticky;

endmodule

// File: tb/tb_a25_wishbone_port_master.sv
// Bench for a25_wishbone_port_master (TIMEOUT_CYCLES=4).
// Vector table of single transactions plus corner sequences.
module tb_a25_wishbone_port_master;

    localparam logic [127:0] ERR =
        128'hdead_dead_dead_dead_dead_dead_dead_dead;
    localparam int M_ACK = 0;
    localparam int M_ERR = 1;
    localparam int M_BOTH = 2;
    localparam int M_TMO = 3;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_accepted;
    logic         i_write;
    logic [127:0] i_wdata;
    logic [15:0]  i_be;
    logic [31:0]  i_addr;
    logic [127:0] o_rdata;
    logic         o_rdata_valid;
    logic [31:0]  o_wb_adr;
    logic [15:0]  o_wb_sel;
    logic         o_wb_we;
    logic [127:0] o_wb_dat;
    logic         o_wb_cyc;
    logic         o_wb_stb;
    logic [127:0] i_wb_dat;
    logic         i_wb_ack;
    logic         i_wb_err;
    logic         o_err;
    logic         o_err_sticky;

    a25_wishbone_port_master #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_valid(i_valid),
        .o_accepted(o_accepted),
        .i_write(i_write),
        .i_wdata(i_wdata),
        .i_be(i_be),
        .i_addr(i_addr),
        .o_rdata(o_rdata),
        .o_rdata_valid(o_rdata_valid),
        .o_wb_adr(o_wb_adr),
        .o_wb_sel(o_wb_sel),
        .o_wb_we(o_wb_we),
        .o_wb_dat(o_wb_dat),
        .o_wb_cyc(o_wb_cyc),
        .o_wb_stb(o_wb_stb),
        .i_wb_dat(i_wb_dat),
        .i_wb_ack(i_wb_ack),
        .i_wb_err(i_wb_err),
        .o_err(o_err),
        .o_err_sticky(o_err_sticky)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [15:0]  be;
        logic [127:0] wdata;
        int           waits;
        int           mode;
        logic [127:0] rdat;
        logic [127:0] exp_rdata;
        logic         exp_err;
        int           exp_cyc;
    } vec_t;

    vec_t vecs[7];
    int   n_tests = 0;
    int   n_fail = 0;
    logic exp_sticky = 1'b0;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int  ncyc;
        bit  done;
        ncyc = 0;
        done = 0;
        i_valid = 1'b1;
        i_write = v.wr;
        i_addr  = v.addr;
        i_be    = v.be;
        i_wdata = v.wdata;
        #1;
        check("accept_idle", 128'(o_accepted), 1);
        tick();
        i_valid = 1'b0;
        i_wdata = ~v.wdata;
        i_addr  = ~v.addr;
        for (int c = 0; c < 20 && !done; c++) begin
            if (o_wb_cyc) begin
                ncyc++;
                check("bus_ctrl",
                      {o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr},
                      {1'b1, v.wr, v.be, v.addr});
                check("bus_dat", o_wb_dat, v.wdata);
                if (v.mode != M_TMO &&
                    ncyc == v.waits + 1) begin
                    i_wb_ack = (v.mode != M_ERR);
                    i_wb_err = (v.mode != M_ACK);
                    i_wb_dat = v.rdat;
                end
                tick();
                i_wb_ack = 1'b0;
                i_wb_err = 1'b0;
                i_wb_dat = 128'h5a5a;
            end else begin
                done = 1;
            end
        end
        if (!done)
            check("cyc_bound", 128'(o_wb_cyc), 0);
        exp_sticky = exp_sticky | v.exp_err;
        check("cyc_len", 128'(ncyc), 128'(v.exp_cyc));
        check("done_rvalid", 128'(o_rdata_valid),
              128'(!v.wr));
        if (!v.wr)
            check("done_rdata", o_rdata, v.exp_rdata);
        check("done_err", 128'(o_err), 128'(v.exp_err));
        check("sticky", 128'(o_err_sticky),
              128'(exp_sticky));
        i_valid = 1'b1;
        #1;
        check("accept_done", 128'(o_accepted), 0);
        i_valid = 1'b0;
        tick();
        check("idle_pulses",
              {o_wb_cyc, o_rdata_valid, o_err}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit hit");
        $fatal(1);
    end

    initial begin
        int pulses;
        logic [8:0] exp_acc;

        vecs[0] = '{1'b0, 32'h40, 16'hffff, 128'h0,
                    0, M_ACK, 128'h1, 128'h1, 1'b0, 1};
        vecs[1] = '{1'b1, 32'h100, 16'h000f,
                    128'h1111_2222_3333_4444,
                    3, M_ACK, 128'h0, 128'h0, 1'b0, 4};
        vecs[2] = '{1'b0, 32'h200, 16'h00ff, 128'h7,
                    2, M_ACK, 128'hcafe_f00d_0123,
                    128'hcafe_f00d_0123, 1'b0, 3};
        vecs[3] = '{1'b0, 32'h300, 16'hffff, 128'h0,
                    0, M_BOTH, 128'h1234, ERR, 1'b1, 1};
        vecs[4] = '{1'b1, 32'h400, 16'hf0f0,
                    128'habcd, 1, M_ERR, 128'h0,
                    128'h0, 1'b1, 2};
        vecs[5] = '{1'b0, 32'h500, 16'hffff, 128'h0,
                    0, M_TMO, 128'h0, ERR, 1'b1, 4};
        vecs[6] = '{1'b1, 32'h600, 16'h0001,
                    128'h99, 0, M_TMO, 128'h0,
                    128'h0, 1'b1, 4};

        i_rst    = 1'b1;
        i_valid  = 1'b1;
        i_write  = 1'b0;
        i_wdata  = '0;
        i_be     = '0;
        i_addr   = '0;
        i_wb_dat = '0;
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;

        tick();
        tick();
        check("rst_accept", 128'(o_accepted), 0);
        check("rst_ctrl",
              {o_wb_cyc, o_wb_stb, o_wb_we, o_rdata_valid,
               o_err, o_err_sticky}, 0);
        check("rst_adr_sel", {o_wb_adr, o_wb_sel}, 0);
        check("rst_dat", o_wb_dat, 0);
        check("rst_rdata", o_rdata, 0);
        i_valid = 1'b0;
        i_rst   = 1'b0;
        tick();

        // Slave responses while idle must be ignored.
        i_wb_ack = 1'b1;
        i_wb_err = 1'b1;
        i_wb_dat = 128'hbad;
        tick();
        check("idle_ack_ign",
              {o_wb_cyc, o_rdata_valid, o_err,
               o_err_sticky}, 0);
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        tick();
        check("idle_ack_ign2",
              {o_rdata_valid, o_err, o_err_sticky}, 0);

        for (int i = 0; i < 7; i++)
            run_txn(vecs[i]);

        // i_valid held high: accepts only in IDLE, every
        // third cycle with zero-wait acks.
        exp_acc = 9'b001_001_001;
        pulses = 0;
        i_valid = 1'b1;
        i_write = 1'b1;
        i_addr  = 32'h700;
        for (int k = 0; k < 9; k++) begin
            i_wb_ack = o_wb_cyc;
            #1;
            check("b2b_accept", 128'(o_accepted),
                  128'(exp_acc[k]));
            if (o_accepted)
                pulses++;
            tick();
        end
        i_valid  = 1'b0;
        i_wb_ack = 1'b0;
        check("b2b_pulses", 128'(pulses), 3);
        check("b2b_idle", 128'(o_wb_cyc), 0);
        tick();

        // Reset in the middle of a read beats a same-cycle ack.
        i_valid = 1'b1;
        i_write = 1'b0;
        i_addr  = 32'h800;
        i_be    = 16'h3;
        tick();
        i_valid = 1'b0;
        check("mid_bus_cyc", 128'(o_wb_cyc), 1);
        i_rst    = 1'b1;
        i_wb_ack = 1'b1;
        i_wb_dat = 128'h77;
        i_valid  = 1'b1;
        #1;
        check("mid_rst_accept", 128'(o_accepted), 0);
        tick();
        i_wb_ack = 1'b0;
        check("mid_rst_ctrl",
              {o_wb_cyc, o_wb_stb, o_wb_we, o_rdata_valid,
               o_err, o_err_sticky}, 0);
        check("mid_rst_regs", {o_wb_adr, o_wb_sel}, 0);
        check("mid_rst_rdata", o_rdata, 0);
        i_rst   = 1'b0;
        i_valid = 1'b0;
        exp_sticky = 1'b0;
        tick();
        check("post_rst_idle",
              {o_wb_cyc, o_rdata_valid, o_err}, 0);

        run_txn(vecs[2]);

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
